alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: FIX_PRIO, default 0, 0 = round-robin grant, 1 = requester 0 always wins.
REQ-002 SHALL have ports (name direction width meaning):
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 accepted this cycle.
- req0_s  input  3  requester 0 opcode.
- req0_a  input  4  requester 0 operand a.
- req0_b  input  4  requester 0 operand b.
- req1_valid, req1_ready, req1_s, req1_a, req1_b  same widths and meanings for requester 1.
- rsp_valid  output  1  result register holds a valid result.
- rsp_ready  input  1  consumer takes result this cycle.
- rsp_id  output  1  requester index of held result.
- rsp_f  output  4  held ALU result.
- rsp_zero  output  1  high when rsp_f == 0.

Function
REQ-003 SHALL share one ALU between the two requesters, with opcodes 000 add, 001 sub, 010 AND, 011 OR, 100 NAND, 101 NOR, 110 NOT a, 111 XOR.
REQ-004 SHALL compute add and sub modulo 16, discarding carry and borrow.
REQ-005 SHALL hold one result, so the block has two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-006 SHALL treat the slot as free when state is EMPTY, or when it is FULL and rsp_ready=1 in the same cycle.
REQ-007 SHALL, when the slot is free, assert readyN for exactly one requester with validN=1, chosen by the grant rule; otherwise both readyN SHALL be 0.
REQ-008 SHALL grant the single valid requester when only one is valid.
REQ-009 SHALL, when both are valid and FIX_PRIO=0, grant the requester not granted last.
REQ-010 SHALL, when both are valid and FIX_PRIO=1, always grant requester 0.
REQ-011 SHALL update the round-robin pointer only on an accepted grant.
REQ-012 SHALL allow readyN to depend combinationally on validN and rsp_ready; validN SHALL NOT depend on readyN.
REQ-013 SHALL, on accept at edge N, load the result register with the granted operands' ALU output, rsp_id and rsp_zero, so rsp_valid=1 from edge N onward: one-cycle latency.
REQ-014 SHALL sustain one result per cycle while rsp_ready=1 by draining and refilling the slot on the same edge.
REQ-015 SHALL, in FULL with rsp_ready=0, hold rsp_f, rsp_id and rsp_zero stable and keep both readyN at 0.
REQ-016 SHALL go from FULL to EMPTY when drained with no new accept.
REQ-017 SHALL go from EMPTY to FULL on accept, and stay FULL on drain plus accept in the same cycle.

Reset
REQ-018 SHALL, on a rising clk edge with rst_n=0, force rsp_valid=0, rsp_id=0, rsp_f=0, rsp_zero=0, state EMPTY and last-grant=1, so requester 0 wins first.
REQ-019 SHALL, when reset occurs mid-operation, discard the held result and accept nothing in that cycle.
REQ-020 SHALL hold both readyN at 0 while rst_n=0.

Structure
REQ-021 SHALL place opcode localparams (OP_ADD..OP_XOR) and width constants (DW=4, SW=3) in shared package alu_pkg.
REQ-022 SHALL instantiate the existing alu module once as the only sub-module, with s, a and b muxed from the granted requester.

Verification
REQ-023 SHALL cover, with rsp_ready=1: req0 s=000 a=9 b=9 -> next cycle rsp_valid=1, rsp_id=0, rsp_f=2, rsp_zero=0.
REQ-024 SHALL cover: req1 s=001 a=5 b=5 -> rsp_id=1, rsp_f=0, rsp_zero=1; then s=001 a=3 b=5 -> rsp_f=14.
REQ-025 SHALL cover: both valid for 6 cycles, FIX_PRIO=0, rsp_ready=1 -> rsp_id sequence 0,1,0,1,0,1 and one result per cycle.
REQ-026 SHALL cover: FULL with rsp_ready=0 for 4 cycles -> both readyN=0 and rsp_f/rsp_id unchanged; then rsp_ready=1 -> drain and accept on the same edge.
REQ-027 SHALL cover: rst_n=0 for one cycle while FULL -> rsp_valid=0 next cycle, then with both valid the first grant is to requester 0.
REQ-028 SHALL cover: FIX_PRIO=1 with both valid for 4 cycles -> rsp_id 0,0,0,0 and req1_ready never asserted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the two-requester ALU arbiter.
// Opcode values, datapath widths and the result-slot state.
package alu_pkg;

    localparam int DW = 4;
    localparam int SW = 3;

    localparam logic [SW-1:0] OP_ADD  = 3'b000;
    localparam logic [SW-1:0] OP_SUB  = 3'b001;
    localparam logic [SW-1:0] OP_AND  = 3'b010;
    localparam logic [SW-1:0] OP_OR   = 3'b011;
    localparam logic [SW-1:0] OP_NAND = 3'b100;
    localparam logic [SW-1:0] OP_NOR  = 3'b101;
    localparam logic [SW-1:0] OP_NOTA = 3'b110;
    localparam logic [SW-1:0] OP_XOR  = 3'b111;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu.sv
// Purely combinational 4-bit ALU with eight operations.
// Add and sub wrap modulo 16; carry and borrow are dropped.
module alu
    import alu_pkg::*;
(
    input  logic [SW-1:0] s,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] f
);

    // Opcode decode; every encoding is used so no default is needed.
    always_comb begin
        f = '0;
        unique case (s)
            OP_ADD:  f = a + b;
            OP_SUB:  f = a - b;
            OP_AND:  f = a & b;
            OP_OR:   f = a | b;
            OP_NAND: f = ~(a & b);
            OP_NOR:  f = ~(a | b);
            OP_NOTA: f = ~a;
            OP_XOR:  f = a ^ b;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU; a single result slot holds the output.
// Grant is round-robin or fixed priority; readies are combinational.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int FIX_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [SW-1:0] req0_s,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [SW-1:0] req1_s,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_f,
    output logic          rsp_zero
);

    state_t        state;
    logic          last;
    logic          free;
    logic          pick1;
    logic          grant0;
    logic          grant1;
    logic          accept;
    logic [SW-1:0] s;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] f;

    // Grant selection and operand mux; readies are gated off in reset.
    always_comb begin
        free   = (state == EMPTY) || rsp_ready;
        pick1  = req1_valid &&
                 (!req0_valid || ((FIX_PRIO == 0) && !last));
        grant1 = rst_n && free && pick1;
        grant0 = rst_n && free && req0_valid && !pick1;
        accept = grant0 || grant1;
        s      = pick1 ? req1_s : req0_s;
        a      = pick1 ? req1_a : req0_a;
        b      = pick1 ? req1_b : req0_b;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = (state == FULL);

    alu u_alu (
        .s (s),
        .a (a),
        .b (b),
        .f (f)
    );

    // Slot state, round-robin pointer and result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            last     <= 1'b1;
            rsp_id   <= 1'b0;
            rsp_f    <= '0;
            rsp_zero <= 1'b0;
        end else begin
            case (state)
                EMPTY: if (accept) state <= FULL;
                FULL:  if (rsp_ready && !accept) state <= EMPTY;
                default: state <= EMPTY;
            endcase
            if (accept) begin
                last     <= grant1;
                rsp_id   <= grant1;
                rsp_f    <= f;
                rsp_zero <= (f == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: round-robin and fixed-priority instances
// share stimulus and are compared against a slot-level model.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid, rsp_ready;
    logic [2:0] req0_s, req1_s;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] rdy0, rdy1, rv, rid, rz;
    logic [3:0] rf [2];

    int total = 0;
    int bad = 0;

    int   mv [2], mid [2], mf [2], mz [2], ml [2], eg [2];
    logic o0 [2], o1 [2];
    int   s0, a0, b0, s1, a1, b1;

    always #5 clk = ~clk;

    alu_arbiter #(.FIX_PRIO(0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(rdy0[0]),
        .req0_s(req0_s), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(rdy1[0]),
        .req1_s(req1_s), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rv[0]), .rsp_ready(rsp_ready),
        .rsp_id(rid[0]), .rsp_f(rf[0]), .rsp_zero(rz[0])
    );

    alu_arbiter #(.FIX_PRIO(1)) u_fx (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(rdy0[1]),
        .req0_s(req0_s), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(rdy1[1]),
        .req1_s(req1_s), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rv[1]), .rsp_ready(rsp_ready),
        .rsp_id(rid[1]), .rsp_f(rf[1]), .rsp_zero(rz[1])
    );

    function automatic int ref_alu(int s, int a, int b);
        case (s)
            0: return (a + b) % 16;
            1: return (a - b + 16) % 16;
            2: return a & b;
            3: return a | b;
            4: return 15 - (a & b);
            5: return 15 - (a | b);
            6: return 15 - a;
            default: return a ^ b;
        endcase
    endfunction

    function automatic int ref_grant(bit v0, bit v1, int fix, int last);
        if (v0 && v1) return (fix != 0) ? 0 : 1 - last;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic rnd_ops();
        s0 = $urandom_range(7); a0 = $urandom_range(15);
        b0 = $urandom_range(15); s1 = $urandom_range(7);
        a1 = $urandom_range(15); b1 = $urandom_range(15);
    endtask

    // One clock: drive, sample readies mid-cycle, advance the model.
    task automatic cyc(input bit v0, input bit v1,
                       input bit rr, input bit rst);
        req0_valid = v0; req1_valid = v1;
        rsp_ready = rr; rst_n = rst;
        req0_s = 3'(s0); req0_a = 4'(a0); req0_b = 4'(b0);
        req1_s = 3'(s1); req1_a = 4'(a1); req1_b = 4'(b1);
        #4;
        for (int k = 0; k < 2; k++) begin
            if (rst && (mv[k] == 0 || rr))
                eg[k] = ref_grant(v0, v1, k, ml[k]);
            else
                eg[k] = -1;
            o0[k] = rdy0[k];
            o1[k] = rdy1[k];
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                mv[k] = 0; mid[k] = 0; mf[k] = 0; mz[k] = 0; ml[k] = 1;
            end else if (eg[k] >= 0) begin
                mv[k] = 1; mid[k] = eg[k]; ml[k] = eg[k];
                mf[k] = (eg[k] == 1) ? ref_alu(s1, a1, b1)
                                     : ref_alu(s0, a0, b0);
                mz[k] = (mf[k] == 0) ? 1 : 0;
            end else if (rr) begin
                mv[k] = 0;
            end
        end
    endtask

    task automatic test_reset();
        rnd_ops();
        cyc(1, 1, 1, 0);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o0[k] !== 1'b0 || o1[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_ready k=%0d got=%b%b want=00",
                         k, o0[k], o1[k]);
            end
            total++;
            if (rv[k] !== 1'b0 || rid[k] !== 1'b0 ||
                rf[k] !== 4'd0 || rz[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_out k=%0d got v=%b id=%b f=%0d z=%b want 0",
                         k, rv[k], rid[k], rf[k], rz[k]);
            end
        end
    endtask

    task automatic test_add();
        s0 = 0; a0 = 9; b0 = 9; s1 = 0; a1 = 0; b1 = 0;
        cyc(1, 0, 1, 1);
        total++;
        if (o0[0] !== 1'b1 || o1[0] !== 1'b0) begin
            bad++;
            $display("FAIL add_ready got=%b%b want=10", o0[0], o1[0]);
        end
        total++;
        if (rv[0] !== 1'b1 || rid[0] !== 1'b0 ||
            rf[0] !== 4'd2 || rz[0] !== 1'b0) begin
            bad++;
            $display("FAIL add_rsp got v=%b id=%b f=%0d z=%b want 1 0 2 0",
                     rv[0], rid[0], rf[0], rz[0]);
        end
    endtask

    task automatic test_sub();
        s1 = 1; a1 = 5; b1 = 5;
        cyc(0, 1, 1, 1);
        total++;
        if (rv[0] !== 1'b1 || rid[0] !== 1'b1 ||
            rf[0] !== 4'd0 || rz[0] !== 1'b1) begin
            bad++;
            $display("FAIL sub_zero got v=%b id=%b f=%0d z=%b want 1 1 0 1",
                     rv[0], rid[0], rf[0], rz[0]);
        end
        a1 = 3; b1 = 5;
        cyc(0, 1, 1, 1);
        total++;
        if (rid[0] !== 1'b1 || rf[0] !== 4'd14 || rz[0] !== 1'b0) begin
            bad++;
            $display("FAIL sub_wrap got id=%b f=%0d z=%b want 1 14 0",
                     rid[0], rf[0], rz[0]);
        end
    endtask

    task automatic test_round_robin();
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            rnd_ops();
            cyc(1, 1, 1, 1);
            total++;
            if (rv[0] !== 1'b1 || rid[0] !== 1'(i % 2) ||
                rf[0] !== 4'(mf[0])) begin
                bad++;
                $display("FAIL rr_seq i=%0d got v=%b id=%b f=%0d want 1 %0d %0d",
                         i, rv[0], rid[0], rf[0], i % 2, mf[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] hf;
        logic       hid;
        rnd_ops();
        cyc(1, 0, 1, 1);
        hf = rf[0];
        hid = rid[0];
        for (int i = 0; i < 4; i++) begin
            rnd_ops();
            cyc(1, 1, 0, 1);
            total++;
            if (o0[0] !== 1'b0 || o1[0] !== 1'b0 || rv[0] !== 1'b1 ||
                rf[0] !== hf || rid[0] !== hid) begin
                bad++;
                $display("FAIL bp_hold i=%0d got r=%b%b v=%b f=%0d id=%b want 00 1 %0d %b",
                         i, o0[0], o1[0], rv[0], rf[0], rid[0], hf, hid);
            end
        end
        rnd_ops();
        cyc(1, 1, 1, 1);
        total++;
        if ((o0[0] ^ o1[0]) !== 1'b1 || rv[0] !== 1'b1 ||
            rid[0] !== 1'(mid[0]) || rf[0] !== 4'(mf[0])) begin
            bad++;
            $display("FAIL bp_release got r=%b%b v=%b id=%b f=%0d want id=%0d f=%0d",
                     o0[0], o1[0], rv[0], rid[0], rf[0], mid[0], mf[0]);
        end
    endtask

    task automatic test_reset_mid();
        rnd_ops();
        cyc(0, 1, 1, 1);
        cyc(1, 1, 0, 0);
        total++;
        if (o0[0] !== 1'b0 || o1[0] !== 1'b0 || rv[0] !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid got r=%b%b v=%b want 00 0",
                     o0[0], o1[0], rv[0]);
        end
        rnd_ops();
        cyc(1, 1, 1, 1);
        total++;
        if (rv[0] !== 1'b1 || rid[0] !== 1'b0) begin
            bad++;
            $display("FAIL rst_first got v=%b id=%b want 1 0", rv[0], rid[0]);
        end
    endtask

    task automatic test_fix_prio();
        for (int i = 0; i < 4; i++) begin
            rnd_ops();
            cyc(1, 1, 1, 1);
            total++;
            if (o1[1] !== 1'b0 || rv[1] !== 1'b1 || rid[1] !== 1'b0 ||
                rf[1] !== 4'(ref_alu(s0, a0, b0))) begin
                bad++;
                $display("FAIL fix_prio i=%0d got r1=%b v=%b id=%b f=%0d want 0 1 0 %0d",
                         i, o1[1], rv[1], rid[1], rf[1], ref_alu(s0, a0, b0));
            end
        end
    endtask

    task automatic test_random();
        bit v0, v1, rr, rst;
        for (int n = 0; n < 400; n++) begin
            rnd_ops();
            v0 = 1'($urandom_range(1));
            v1 = 1'($urandom_range(1));
            rr = ($urandom_range(3) != 0);
            rst = ($urandom_range(39) != 0);
            cyc(v0, v1, rr, rst);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (o0[k] !== (eg[k] == 0) || o1[k] !== (eg[k] == 1)) begin
                    bad++;
                    $display("FAIL rnd_ready n=%0d k=%0d got=%b%b want grant %0d",
                             n, k, o0[k], o1[k], eg[k]);
                end
                total++;
                if (rv[k] !== 1'(mv[k]) || rid[k] !== 1'(mid[k]) ||
                    rf[k] !== 4'(mf[k]) || rz[k] !== 1'(mz[k])) begin
                    bad++;
                    $display("FAIL rnd_rsp n=%0d k=%0d got %b %b %0d %b want %0d %0d %0d %0d",
                             n, k, rv[k], rid[k], rf[k], rz[k],
                             mv[k], mid[k], mf[k], mz[k]);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mv[k] = 0; mid[k] = 0; mf[k] = 0; mz[k] = 0; ml[k] = 1;
        end
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_s = '0; req0_a = '0; req0_b = '0;
        req1_s = '0; req1_a = '0; req1_b = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_sub();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_fix_prio();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
